// File: rtl/pam4_dfe_slicer_if.sv
// Sample/decision bus of the PAM-4 DFE slicer: equalizer inputs, tap control and
// registered decisions. The slave side is the slicer itself.
interface pam4_dfe_slicer_if #(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int DFE_TAPS          = 2,
  parameter int TAP_WIDTH         = 8
);
  logic signed [SIGNAL_RESOLUTION-1:0] signal_in;
  logic                                signal_in_valid;
  logic                                adapt_en;
  logic                                load_taps;
  logic [DFE_TAPS*TAP_WIDTH-1:0]       tap_init;
  logic [1:0]                          symbol_out;
  logic                                symbol_out_valid;
  logic signed [SIGNAL_RESOLUTION-1:0] eq_out;
  logic signed [SIGNAL_RESOLUTION-1:0] err_out;
  logic [DFE_TAPS*TAP_WIDTH-1:0]       taps_out;

  modport master (
    output signal_in, signal_in_valid, adapt_en, load_taps, tap_init,
    input  symbol_out, symbol_out_valid, eq_out, err_out, taps_out
  );
  modport slave (
    input  signal_in, signal_in_valid, adapt_en, load_taps, tap_init,
    output symbol_out, symbol_out_valid, eq_out, err_out, taps_out
  );
endinterface

// File: rtl/pam4_dfe_slicer.sv
// PAM-4 decision-feedback equalizer and slicer with sign-sign LMS tap adaptation.
// One sample per cycle, single-cycle feedback loop, results registered one cycle later.

module pam4_dfe_tap #(
  parameter int TW = 8,
  parameter int SR = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic signed [SR-1:0]  i_d,
  input  logic                  i_upd,
  input  logic                  i_epos,
  input  logic                  i_eneg,
  input  logic                  i_load,
  input  logic signed [TW-1:0]  i_init,
  output logic signed [TW-1:0]  o_tap,
  output logic signed [TW+SR-1:0] o_prod
);
  localparam int PW = TW + SR;
  localparam logic signed [TW-1:0] TMAX = {1'b0, {(TW-1){1'b1}}};
  localparam logic signed [TW-1:0] TMIN = {1'b1, {(TW-1){1'b0}}};

  logic signed [TW-1:0] r_tap;
  logic w_dpos, w_dneg, w_inc, w_dec;

  // sign(0)=0 on the history side keeps reset zeros from driving updates
  assign w_dneg = i_d[SR-1];
  assign w_dpos = !i_d[SR-1] && (i_d != '0);
  assign w_inc  = i_upd && ((i_epos && w_dpos) || (i_eneg && w_dneg)) && (r_tap != TMAX);
  assign w_dec  = i_upd && ((i_epos && w_dneg) || (i_eneg && w_dpos)) && (r_tap != TMIN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       r_tap <= '0;
    else if (i_load) r_tap <= i_init;
    else if (w_inc)  r_tap <= r_tap + TW'(1);
    else if (w_dec)  r_tap <= r_tap - TW'(1);
  end

  assign o_tap  = r_tap;
  assign o_prod = PW'(r_tap) * PW'(i_d);
endmodule

module pam4_dfe_slicer #(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56,
  parameter int DFE_TAPS          = 2,
  parameter int TAP_WIDTH         = 8,
  parameter int TAP_FRAC          = 6
) (
  input logic              clk,
  input logic              rstn,
  pam4_dfe_slicer_if.slave bus
);
  localparam int SR = SIGNAL_RESOLUTION;
  localparam int TW = TAP_WIDTH;
  localparam int PW = SR + TW;
  localparam int W  = SR + TW + $clog2(DFE_TAPS) + 2;
  localparam logic signed [W-1:0] SEP  = W'(SYMBOL_SEPERATION);
  localparam logic signed [W-1:0] SMAX = W'((1 << (SR-1)) - 1);
  localparam logic signed [W-1:0] SMIN = W'(-(1 << (SR-1)));

  function automatic logic signed [W-1:0] lvl(input logic [1:0] s);
    return W'((2 * int'(s) - 3) * SYMBOL_SEPERATION / 2);
  endfunction

  function automatic logic signed [SR-1:0] sat(input logic signed [W-1:0] v);
    if (v > SMAX)      return SMAX[SR-1:0];
    else if (v < SMIN) return SMIN[SR-1:0];
    else               return v[SR-1:0];
  endfunction

  logic signed [SR-1:0] r_hist [DFE_TAPS];
  logic signed [TW-1:0] w_tap  [DFE_TAPS];
  logic signed [PW-1:0] w_prod [DFE_TAPS];
  logic signed [W-1:0]  w_acc, w_fb, w_y, w_e, w_lvl;
  logic [1:0]           w_sym, r_sym;
  logic signed [SR-1:0] r_eq, r_err;
  logic                 r_vld, w_epos, w_eneg, w_upd;

  for (genvar k = 0; k < DFE_TAPS; k++) begin : g_tap
    pam4_dfe_tap #(.TW(TW), .SR(SR)) u_tap (
      .clk    (clk),
      .rstn   (rstn),
      .i_d    (r_hist[k]),
      .i_upd  (w_upd),
      .i_epos (w_epos),
      .i_eneg (w_eneg),
      .i_load (bus.load_taps),
      .i_init (bus.tap_init[k*TW +: TW]),
      .o_tap  (w_tap[k]),
      .o_prod (w_prod[k])
    );
    assign bus.taps_out[k*TW +: TW] = w_tap[k];
  end

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < DFE_TAPS; k++) w_acc = w_acc + W'(w_prod[k]);
  end

  // floor shift, applied only after the full-precision sum
  assign w_fb = w_acc >>> TAP_FRAC;
  assign w_y  = W'($signed(bus.signal_in)) - w_fb;

  always_comb begin
    if (w_y < -SEP)   w_sym = 2'd0;
    else if (w_y[W-1]) w_sym = 2'd1;
    else if (w_y < SEP) w_sym = 2'd2;
    else              w_sym = 2'd3;
  end

  assign w_lvl  = lvl(w_sym);
  assign w_e    = w_y - w_lvl;
  assign w_epos = !w_e[W-1] && (w_e != '0);
  assign w_eneg = w_e[W-1];
  assign w_upd  = bus.signal_in_valid && bus.adapt_en && !bus.load_taps;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sym <= '0;
      r_vld <= 1'b0;
      r_eq  <= '0;
      r_err <= '0;
      for (int k = 0; k < DFE_TAPS; k++) r_hist[k] <= '0;
    end else begin
      r_vld <= bus.signal_in_valid;
      if (bus.signal_in_valid) begin
        r_sym     <= w_sym;
        r_eq      <= sat(w_y);
        r_err     <= sat(w_e);
        r_hist[0] <= w_lvl[SR-1:0];
        for (int k = 1; k < DFE_TAPS; k++) r_hist[k] <= r_hist[k-1];
      end
    end
  end

  assign bus.symbol_out       = r_sym;
  assign bus.symbol_out_valid = r_vld;
  assign bus.eq_out           = r_eq;
  assign bus.err_out          = r_err;
endmodule

// File: tb/tb_pam4_dfe_slicer.sv
// Directed checks of the PAM-4 DFE slicer: reset, pass-through, fixed ISI cancellation,
// LMS convergence on h=[1,0.5], tap saturation and load/adapt collision.
module tb_pam4_dfe_slicer;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_tot = 0;
  int   n_bad = 0;

  pam4_dfe_slicer_if bus ();
  pam4_dfe_slicer dut (.clk(clk), .rstn(rstn), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tot++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int tap(input int k);
    logic signed [7:0] t;
    t = bus.taps_out[k*8 +: 8];
    return int'(t);
  endfunction

  function automatic int lv(input int s);
    return (2 * s - 3) * 28;
  endfunction

  // drive one cycle, sample 1 time unit after the rising edge
  task automatic cyc(input int s, input bit v, input bit ld);
    bus.signal_in       = 8'(s);
    bus.signal_in_valid = v;
    bus.load_taps       = ld;
    @(posedge clk);
    #1;
    bus.signal_in_valid = 1'b0;
    bus.load_taps       = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int sym, input int eq, input int err);
    chk({tag, "_vld"}, int'(bus.symbol_out_valid), 1);
    chk({tag, "_sym"}, int'(bus.symbol_out), sym);
    chk({tag, "_eq"},  int'(bus.eq_out), eq);
    chk({tag, "_err"}, int'(bus.err_out), err);
  endtask

  task automatic set_taps(input int t0, input int t1);
    bus.tap_init = {8'(t1), 8'(t0)};
    cyc(0, 1'b0, 1'b1);
  endtask

  task automatic rst_pulse();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
  endtask

  initial begin
    int fin [4]  = '{84, 126, -42, -14};
    int fsym [4] = '{3, 3, 0, 2};
    int feq [4]  = '{84, 84, -84, 28};
    int prev, sym, errs;

    bus.signal_in = '0; bus.signal_in_valid = 1'b0; bus.adapt_en = 1'b0;
    bus.load_taps = 1'b0; bus.tap_init = '0;
    #1;
    chk("rst_sym", int'(bus.symbol_out), 0);
    chk("rst_vld", int'(bus.symbol_out_valid), 0);
    chk("rst_eq",  int'(bus.eq_out), 0);
    chk("rst_err", int'(bus.err_out), 0);
    chk("rst_taps", int'(bus.taps_out), 0);
    #10 rstn = 1'b1;

    for (int s = 0; s < 4; s++) begin
      cyc(lv(s), 1'b1, 1'b0);
      chk_out($sformatf("pass%0d", s), s, lv(s), 0);
    end
    cyc(0, 1'b0, 1'b0);
    chk("idle_vld", int'(bus.symbol_out_valid), 0);

    rst_pulse();
    set_taps(32, 0);
    chk("ld_tap0", tap(0), 32);
    chk("ld_tap1", tap(1), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(fin[i], 1'b1, 1'b0);
      chk_out($sformatf("fix%0d", i), fsym[i], feq[i], 0);
    end

    // asynchronous reset between edges
    rstn = 1'b0;
    #1;
    chk("arst_sym",  int'(bus.symbol_out), 0);
    chk("arst_vld",  int'(bus.symbol_out_valid), 0);
    chk("arst_eq",   int'(bus.eq_out), 0);
    chk("arst_taps", int'(bus.taps_out), 0);
    #1 rstn = 1'b1;
    cyc(84, 1'b1, 1'b0);
    chk("post_rst0_sym", int'(bus.symbol_out), 3);
    cyc(-84, 1'b1, 1'b0);
    chk("post_rst1_sym", int'(bus.symbol_out), 0);

    // LMS convergence on h=[1,0.5]
    rst_pulse();
    bus.adapt_en = 1'b1;
    prev = 0; errs = 0;
    for (int i = 0; i < 2000; i++) begin
      sym = int'($urandom_range(0, 3));
      cyc(lv(sym) + prev / 2, 1'b1, 1'b0);
      if (i >= 200 && int'(bus.symbol_out) != sym) errs++;
      prev = lv(sym);
    end
    bus.adapt_en = 1'b0;
    chk("adapt_errs", errs, 0);
    chk("adapt_tap0_in_30_34", int'(tap(0) >= 30 && tap(0) <= 34), 1);
    chk("adapt_tap1_in_m2_2", int'(tap(1) >= -2 && tap(1) <= 2), 1);

    // tap0 pinned at +127 while every step pushes it up
    rst_pulse();
    set_taps(127, 0);
    bus.adapt_en = 1'b1;
    cyc(-84, 1'b1, 1'b0);
    chk_out("satA", 0, -84, 0);
    cyc(-100, 1'b1, 1'b0);
    chk_out("satB", 3, 67, -17);
    chk("satB_tap0", tap(0), 127);
    chk("satB_tap1", tap(1), 0);
    cyc(86, 1'b1, 1'b0);
    chk_out("satC", 0, -80, 4);
    chk("satC_tap0", tap(0), 127);
    chk("satC_tap1", tap(1), -1);
    cyc(-100, 1'b1, 1'b0);
    chk_out("satD", 3, 68, -16);
    chk("satD_tap0", tap(0), 127);
    chk("satD_tap1", tap(1), -2);

    // load in the same cycle as a valid, adapting sample
    bus.tap_init = {8'sd5, 8'sd10};
    cyc(100, 1'b1, 1'b1);
    chk_out("ldv", 0, -69, 15);
    chk("ldv_tap0", tap(0), 10);
    chk("ldv_tap1", tap(1), 5);
    bus.adapt_en = 1'b0;
    cyc(21, 1'b1, 1'b0);
    chk_out("newtap", 2, 28, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
